// File: rtl/alu_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl_if
// Brief    : Upstream, ALU-side and downstream signals of the execute sequencer.
// Revision : 1.0
// ============================================================================
interface alu_exec_ctrl_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [3:0]       funct;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [4:0]       sh_amt;
    logic [2:0]       op;
    logic             binvert;
    logic             cin;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, alu_op, funct, reg_a, reg_b, sh_amt, alu_result, out_ready,
        input  in_ready, op, binvert, cin, alu_a, alu_b, out_valid, result, zero,
               overflow, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct, reg_a, reg_b, sh_amt, alu_result, out_ready,
        output in_ready, op, binvert, cin, alu_a, alu_b, out_valid, result, zero,
               overflow, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Brief    : Execute-stage sequencer for the sliced ALU; optional logical
//            shifts are built when ALU_SHIFT_EN is defined.
// Revision : 1.0
// ============================================================================
module alu_exec_ctrl #(
    parameter int WIDTH = 24
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_exec_ctrl_if.slave bus
);
    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SLT = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;

    localparam logic [1:0] c_K_ALU = 2'd0;
    localparam logic [1:0] c_K_ILL = 2'd3;
`ifdef ALU_SHIFT_EN
    localparam logic [1:0] c_K_SLL = 2'd1;
    localparam logic [1:0] c_K_SRL = 2'd2;
`endif

    localparam logic [1:0] c_OV_NONE = 2'd0;
    localparam logic [1:0] c_OV_ADD  = 2'd1;
    localparam logic [1:0] c_OV_SUB  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_binv;
    logic             r_cin;
    logic [1:0]       r_ovf_mode;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_illegal;

    logic [2:0]       w_op;
    logic             w_binv;
    logic             w_cin;
    logic [1:0]       w_kind;
    logic [1:0]       w_ovf_mode;
    logic             w_b_sign;
    logic             w_ovf;

    always_comb begin
        w_op       = c_OP_AND;
        w_binv     = 1'b0;
        w_cin      = 1'b0;
        w_kind     = c_K_ILL;
        w_ovf_mode = c_OV_NONE;
        case (bus.alu_op)
            2'b00: begin
                w_op = c_OP_ADD; w_kind = c_K_ALU; w_ovf_mode = c_OV_ADD;
            end
            2'b01: begin
                w_op = c_OP_ADD; w_binv = 1'b1; w_cin = 1'b1;
                w_kind = c_K_ALU; w_ovf_mode = c_OV_SUB;
            end
            2'b10: begin
                case (bus.funct)
                    4'b0000: begin
                        w_op = c_OP_ADD; w_kind = c_K_ALU; w_ovf_mode = c_OV_ADD;
                    end
                    4'b0001: begin
                        w_op = c_OP_ADD; w_binv = 1'b1; w_cin = 1'b1;
                        w_kind = c_K_ALU; w_ovf_mode = c_OV_SUB;
                    end
                    4'b0010: begin w_op = c_OP_AND; w_kind = c_K_ALU; end
                    4'b0011: begin w_op = c_OP_OR;  w_kind = c_K_ALU; end
                    4'b0100: begin w_op = c_OP_XOR; w_kind = c_K_ALU; end
                    4'b0101: begin
                        w_op = c_OP_SLT; w_binv = 1'b1; w_cin = 1'b1; w_kind = c_K_ALU;
                    end
`ifdef ALU_SHIFT_EN
                    4'b1000: w_kind = c_K_SLL;
                    4'b1001: w_kind = c_K_SRL;
`endif
                    default: w_kind = c_K_ILL;
                endcase
            end
            default: w_kind = c_K_ILL;
        endcase
    end

    // Subtraction feeds ~B into the adder, so its sign bit is flipped before the add rule.
    assign w_b_sign = (r_ovf_mode == c_OV_SUB) ? ~r_b[WIDTH-1] : r_b[WIDTH-1];
    assign w_ovf    = (r_ovf_mode != c_OV_NONE) && (r_a[WIDTH-1] == w_b_sign) &&
                      (bus.alu_result[WIDTH-1] != r_a[WIDTH-1]);

`ifdef ALU_SHIFT_EN
    logic [WIDTH-1:0] r_sh;
    logic [4:0]       r_cnt;
    logic             r_dir;
    logic [WIDTH-1:0] w_sh_next;
    logic [4:0]       w_cnt_init;

    assign w_sh_next  = r_dir ? (r_sh >> 1) : (r_sh << 1);
    assign w_cnt_init = (32'(bus.sh_amt) > 32'(WIDTH)) ? 5'(WIDTH) : bus.sh_amt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= c_OP_AND;
            r_binv      <= 1'b0;
            r_cin       <= 1'b0;
            r_ovf_mode  <= c_OV_NONE;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
`ifdef ALU_SHIFT_EN
            r_sh        <= '0;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.reg_a;
                        r_b        <= bus.reg_b;
                        r_in_ready <= 1'b0;
                        r_ovf_mode <= w_ovf_mode;
                        case (w_kind)
                            c_K_ALU: begin
                                r_op    <= w_op;
                                r_binv  <= w_binv;
                                r_cin   <= w_cin;
                                r_state <= S_EXEC;
                            end
`ifdef ALU_SHIFT_EN
                            c_K_SLL, c_K_SRL: begin
                                r_sh  <= bus.reg_a;
                                r_dir <= (w_kind == c_K_SRL);
                                r_cnt <= w_cnt_init;
                                if (bus.sh_amt == 5'd0) begin
                                    r_result    <= bus.reg_a;
                                    r_zero      <= (bus.reg_a == '0);
                                    r_overflow  <= 1'b0;
                                    r_illegal   <= 1'b0;
                                    r_out_valid <= 1'b1;
                                    r_state     <= S_DONE;
                                end else begin
                                    r_state <= S_SHIFT;
                                end
                            end
`endif
                            default: begin
                                r_result    <= '0;
                                r_zero      <= 1'b1;
                                r_overflow  <= 1'b0;
                                r_illegal   <= 1'b1;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    r_result    <= bus.alu_result;
                    r_zero      <= (bus.alu_result == '0);
                    r_overflow  <= w_ovf;
                    r_illegal   <= 1'b0;
                    r_op        <= c_OP_AND;
                    r_binv      <= 1'b0;
                    r_cin       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
`ifdef ALU_SHIFT_EN
                S_SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_result    <= w_sh_next;
                        r_zero      <= (w_sh_next == '0);
                        r_overflow  <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.op        = r_op;
    assign bus.binvert   = r_binv;
    assign bus.cin       = r_cin;
    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_overflow;
    assign bus.illegal   = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_ctrl
// Brief    : Self-checking bench for alu_exec_ctrl with a behavioural sliced ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_exec_ctrl;
    localparam int W = 24;
    localparam logic [W-1:0] c_MASK = {W{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl_if #(.WIDTH(W)) bus ();

    alu_exec_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural stand-in for the 1-bit-slice ALU.
    logic [W-1:0] alu_sum;
    always_comb begin
        alu_sum = bus.alu_a + (bus.binvert ? ~bus.alu_b : bus.alu_b) + W'(bus.cin);
        case (bus.op)
            3'b000:  bus.alu_result = bus.alu_a & bus.alu_b;
            3'b001:  bus.alu_result = bus.alu_a | bus.alu_b;
            3'b010:  bus.alu_result = alu_sum;
            3'b011:  bus.alu_result = W'(alu_sum[W-1]);
            3'b100:  bus.alu_result = bus.alu_a ^ bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    // Reference model computed straight from the operation definitions.
    task automatic model(input logic [1:0] aop, input logic [3:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh,
                         output logic [W-1:0] res, output logic zf, output logic of,
                         output logic il, output int lat, output logic [2:0] op,
                         output logic binv, output logic cin);
        logic [W-1:0] diff;
        int           n;
        int           code;
        diff = a - b;
        res = '0; of = 1'b0; il = 1'b0; lat = 2; op = 3'b000; binv = 1'b0; cin = 1'b0;
        if (aop == 2'b00) code = 0;
        else if (aop == 2'b01) code = 1;
        else if (aop == 2'b10) code = int'(fn);
        else code = 99;
`ifndef ALU_SHIFT_EN
        if (code == 8 || code == 9) code = 99;
`endif
        case (code)
            0: begin
                res = a + b; op = 3'b010;
                of = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            1: begin
                res = diff; op = 3'b010; binv = 1'b1; cin = 1'b1;
                of = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            2: begin res = a & b; op = 3'b000; end
            3: begin res = a | b; op = 3'b001; end
            4: begin res = a ^ b; op = 3'b100; end
            5: begin res = W'(diff[W-1]); op = 3'b011; binv = 1'b1; cin = 1'b1; end
            8, 9: begin
                n   = (int'(sh) > W) ? W : int'(sh);
                lat = (n == 0) ? 1 : n + 1;
                if (n >= W) res = '0;
                else if (code == 8) res = a << n;
                else res = a >> n;
            end
            default: begin il = 1'b1; lat = 1; end
        endcase
        zf = (res == '0);
    endtask

    // Drives one operation, holds off acceptance of the result for `hold` cycles.
    task automatic issue(input logic [1:0] aop, input logic [3:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh,
                         input int hold, output int lat, output logic [2:0] c_op,
                         output logic c_binv, output logic c_cin, output logic [W-1:0] res,
                         output logic zf, output logic of, output logic il,
                         output logic stable, output logic rdy_after, output logic ov_after);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1; bus.alu_op = aop; bus.funct = fn;
        bus.reg_a = a; bus.reg_b = b; bus.sh_amt = sh;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.reg_a = W'($urandom); bus.reg_b = W'($urandom);
        c_op = bus.op; c_binv = bus.binvert; c_cin = bus.cin;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        res = bus.result; zf = bus.zero; of = bus.overflow; il = bus.illegal;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1; bus.alu_op = 2'b00; bus.reg_a = W'($urandom);
            @(negedge clk);
            if (bus.result !== res || bus.zero !== zf || bus.overflow !== of ||
                bus.illegal !== il || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        rdy_after = bus.in_ready;
        ov_after  = bus.out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: got in_ready=%b out_valid=%b expected 1/0",
                     bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.result !== '0 || bus.zero !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: got result=%h z=%b v=%b il=%b expected 0/0/0/0",
                     bus.result, bus.zero, bus.overflow, bus.illegal);
        end
        checks++;
        if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.op !== 3'b000 ||
            bus.binvert !== 1'b0 || bus.cin !== 1'b0) begin
            errors++;
            $display("FAIL reset_alu_side: got a=%h b=%h op=%b binv=%b cin=%b expected all 0",
                     bus.alu_a, bus.alu_b, bus.op, bus.binvert, bus.cin);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        int lat; logic [2:0] cop; logic cb, cc, zf, of, il, st, ra, oa; logic [W-1:0] res;
        issue(2'b00, 4'h0, 24'h7FFFFF, 24'h000001, 5'd0, 0,
              lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
        checks++;
        if (cop !== 3'b010 || cb !== 1'b0 || cc !== 1'b0) begin
            errors++;
            $display("FAIL add_ctrl: got op=%b binv=%b cin=%b expected 010/0/0", cop, cb, cc);
        end
        checks++;
        if (res !== 24'h800000 || of !== 1'b1 || zf !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got %h v=%b z=%b expected 800000 v=1 z=0", res, of, zf);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL add_latency: got %0d expected 2", lat);
        end
    endtask

    task automatic test_sub_zero();
        int lat; logic [2:0] cop; logic cb, cc, zf, of, il, st, ra, oa; logic [W-1:0] res;
        issue(2'b01, 4'h0, 24'h123456, 24'h123456, 5'd0, 0,
              lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
        checks++;
        if (cop !== 3'b010 || cb !== 1'b1 || cc !== 1'b1) begin
            errors++;
            $display("FAIL sub_ctrl: got op=%b binv=%b cin=%b expected 010/1/1", cop, cb, cc);
        end
        checks++;
        if (res !== '0 || zf !== 1'b1 || of !== 1'b0) begin
            errors++;
            $display("FAIL sub_result: got %h z=%b v=%b expected 0 z=1 v=0", res, zf, of);
        end
    endtask

    task automatic test_slt();
        int lat; logic [2:0] cop; logic cb, cc, zf, of, il, st, ra, oa; logic [W-1:0] res;
        issue(2'b10, 4'h5, 24'hFFFFFF, 24'h000001, 5'd0, 0,
              lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
        checks++;
        if (cop !== 3'b011 || res !== 24'h000001 || of !== 1'b0) begin
            errors++;
            $display("FAIL slt: got op=%b result=%h v=%b expected 011 000001 v=0", cop, res, of);
        end
    endtask

    task automatic test_shift();
        int lat; logic [2:0] cop; logic cb, cc, zf, of, il, st, ra, oa; logic [W-1:0] res;
`ifdef ALU_SHIFT_EN
        issue(2'b10, 4'h8, 24'h000001, 24'h0, 5'd23, 0,
              lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
        checks++;
        if (res !== 24'h800000 || lat !== 24 || il !== 1'b0) begin
            errors++;
            $display("FAIL sll23: got %h lat=%0d il=%b expected 800000 lat=24 il=0", res, lat, il);
        end
        issue(2'b10, 4'h8, 24'h000001, 24'h0, 5'd31, 0,
              lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
        checks++;
        if (res !== '0 || lat !== 25 || zf !== 1'b1) begin
            errors++;
            $display("FAIL sll31: got %h lat=%0d z=%b expected 0 lat=25 z=1", res, lat, zf);
        end
        issue(2'b10, 4'h9, 24'hA50000, 24'h0, 5'd0, 0,
              lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
        checks++;
        if (res !== 24'hA50000 || lat !== 1) begin
            errors++;
            $display("FAIL srl0: got %h lat=%0d expected A50000 lat=1", res, lat);
        end
`else
        issue(2'b10, 4'h8, 24'h000001, 24'h0, 5'd23, 0,
              lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
        checks++;
        if (il !== 1'b1 || res !== '0 || zf !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL sll_disabled: got il=%b res=%h z=%b lat=%0d expected 1 0 1 1",
                     il, res, zf, lat);
        end
`endif
        issue(2'b11, 4'h0, 24'h1, 24'h2, 5'd0, 0,
              lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
        checks++;
        if (il !== 1'b1 || res !== '0 || zf !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL illegal_aluop: got il=%b res=%h z=%b lat=%0d expected 1 0 1 1",
                     il, res, zf, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [2:0] cop; logic cb, cc, zf, of, il, st, ra, oa; logic [W-1:0] res;
        issue(2'b10, 4'h4, 24'hF0F0F0, 24'hFFFFFF, 5'd0, 10,
              lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
        checks++;
        if (res !== 24'h0F0F0F || cop !== 3'b100) begin
            errors++;
            $display("FAIL bp_result: got %h op=%b expected 0F0F0F op=100", res, cop);
        end
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable: got %b expected 1", st);
        end
        checks++;
        if (ra !== 1'b1 || oa !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", ra, oa);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat; logic [2:0] cop; logic cb, cc, zf, of, il, st, ra, oa; logic [W-1:0] res;
        logic seen;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_op = 2'b10;
`ifdef ALU_SHIFT_EN
        bus.funct = 4'h8;
`else
        bus.funct = 4'h4;
`endif
        bus.reg_a = 24'h000003; bus.reg_b = 24'h00FF00; bus.sh_amt = 5'd20;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== '0 ||
            bus.alu_a !== '0) begin
            errors++;
            $display("FAIL midreset_state: got in_ready=%b out_valid=%b result=%h a=%h expected 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.result, bus.alu_a);
        end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_discard: got out_valid=%b expected 0", seen);
        end
        issue(2'b00, 4'h0, 24'h000005, 24'h000007, 5'd0, 0,
              lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
        checks++;
        if (res !== 24'h00000C || lat !== 2 || of !== 1'b0) begin
            errors++;
            $display("FAIL midreset_add: got %h lat=%0d v=%b expected 00000C lat=2 v=0",
                     res, lat, of);
        end
    endtask

    task automatic test_random();
        int lat, elat; logic [2:0] cop, eop; logic cb, cc, eb, ec;
        logic zf, of, il, st, ra, oa, ez, eo, ei; logic [W-1:0] res, eres, a, b;
        logic [1:0] aop; logic [3:0] fn; logic [4:0] sh;
        logic [3:0] fpick [9];
        fpick = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hE};
        for (int k = 0; k < 40; k++) begin
            aop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            fn  = fpick[$urandom_range(0, 8)];
            a   = W'($urandom) & c_MASK;
            b   = ($urandom_range(0, 4) == 0) ? a : (W'($urandom) & c_MASK);
            sh  = 5'($urandom_range(0, 31));
            model(aop, fn, a, b, sh, eres, ez, eo, ei, elat, eop, eb, ec);
            issue(aop, fn, a, b, sh, $urandom_range(0, 2),
                  lat, cop, cb, cc, res, zf, of, il, st, ra, oa);
            checks++;
            if (res !== eres || zf !== ez || of !== eo || il !== ei) begin
                errors++;
                $display("FAIL rand_result[%0d]: aop=%b fn=%h a=%h b=%h sh=%0d got %h z%b v%b i%b expected %h z%b v%b i%b",
                         k, aop, fn, a, b, sh, res, zf, of, il, eres, ez, eo, ei);
            end
            checks++;
            if (lat !== elat || cop !== eop || cb !== eb || cc !== ec) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got lat=%0d op=%b b=%b c=%b expected lat=%0d op=%b b=%b c=%b",
                         k, lat, cop, cb, cc, elat, eop, eb, ec);
            end
            checks++;
            if (st !== 1'b1 || ra !== 1'b1 || oa !== 1'b0) begin
                errors++;
                $display("FAIL rand_handshake[%0d]: got stable=%b in_ready=%b out_valid=%b expected 1 1 0",
                         k, st, ra, oa);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.funct = 4'h0;
        bus.reg_a = '0; bus.reg_b = '0; bus.sh_amt = 5'd0; bus.out_ready = 1'b0;
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_slt();
        test_shift();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
